// File: rtl/video_timing_gen.sv
// video_timing_gen
// ----------------
// Free-running raster timing generator for the HDMI output path. A pixel
// counter pair (x, y) walks the full raster including blanking, and the sync,
// data-enable and frame strobes are decoded from it. A single-cycle vreset
// pulse from the video analysis side snaps the raster to the first active
// pixel (0,0) so the outgoing frame lines up with the core's video.
//
// Default parameters give 720x576@50 Hz on a 27 MHz pixel clock
// (864 x 625 total).
//
// Optional build macro:
//   VIDEO_TIMING_GEN_LOCK_DET_EN - builds the vreset alignment detector that
//                                  drives 'locked'. Without it 'locked' is 0.
//
// Ports:
//   clk     in   1   pixel clock
//   reset   in   1   asynchronous, active-high reset
//   vreset  in   1   single-cycle realign request, synchronous to clk
//   hs      out  1   horizontal sync, active level HS_POL
//   vs      out  1   vertical sync, active level VS_POL
//   de      out  1   data enable, high in the active area
//   x       out  12  horizontal position
//   y       out  11  vertical position
//   frame   out  1   one-cycle pulse while the raster is at (0,0)
//   locked  out  1   vreset alignment status
module video_timing_gen #(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 12,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 68,
  parameter int V_ACTIVE = 576,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 39,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vreset,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame,
  output logic        locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] X_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] X_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        frame_q, frame_d;

  // Next raster position. vreset wins over normal counting and truncates
  // whatever line/frame is in progress. Resetting from the last pixel of the
  // frame lands on (0,0) exactly as the natural wrap would.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vreset) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 11'd1;
    end else begin
      x_d = x_q + 12'd1;
    end
  end

  // Strobes are decoded from the next position rather than the current one,
  // so once registered they describe the same pixel as x/y (zero skew).
  // vs depends on y only, which makes it switch on whole-line boundaries.
  always_comb begin
    de_d    = (x_d < X_ACT) && (y_d < Y_ACT);
    hs_d    = ((x_d >= HS_START) && (x_d <= HS_END)) ? HS_POL : ~HS_POL;
    vs_d    = ((y_d >= VS_START) && (y_d <= VS_END)) ? VS_POL : ~VS_POL;
    frame_d = (x_d == '0) && (y_d == '0);
  end

  // Raster and strobe registers. Reset parks the raster on the last pixel of
  // the frame so the first edge after release produces (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= X_LAST;
      y_q     <= Y_LAST;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      frame_q <= frame_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign de    = de_q;
  assign frame = frame_q;

`ifdef VIDEO_TIMING_GEN_LOCK_DET_EN
  logic [1:0] lock_cnt_q, lock_cnt_d;
  logic       locked_q, locked_d;
  logic       aligned;

  // A vreset is aligned when it hits the pixel where the raster would wrap
  // anyway. Two aligned requests in a row declare lock; any misaligned one
  // clears the history and drops lock. Frames without a vreset change nothing.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    aligned    = (x_q == X_LAST) && (y_q == Y_LAST);
    if (vreset) begin
      if (aligned) begin
        if (lock_cnt_q != 2'd3) begin
          lock_cnt_d = lock_cnt_q + 2'd1;
        end
        if (lock_cnt_d[1]) begin
          locked_d = 1'b1;
        end
      end else begin
        lock_cnt_d = 2'd0;
        locked_d   = 1'b0;
      end
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running raster timing generator. Produces hs/vs/de and pixel coordinates for the HDMI output path.
- Accepts a single-cycle vreset pulse from the video analysis side. The pulse snaps the raster to the first active pixel (0,0), so the HDMI frame aligns with the core's video.
- Default parameters give 720x576@50 Hz on a 27 MHz pixel clock.

Parameters:
- H_ACTIVE, 720, active pixels per line
- H_FP, 12, horizontal front porch in pixels
- H_SYNC, 64, hsync width in pixels
- H_BP, 68, horizontal back porch in pixels
- V_ACTIVE, 576, active lines per frame
- V_FP, 5, vertical front porch in lines
- V_SYNC, 5, vsync width in lines
- V_BP, 39, vertical back porch in lines
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- vreset  in  1  single-cycle realign request, synchronous to clk
- hs  out  1  horizontal sync, polarity set by HS_POL
- vs  out  1  vertical sync, polarity set by VS_POL
- de  out  1  data enable, high in the active area
- x  out  12  horizontal position counter
- y  out  11  vertical position counter
- frame  out  1  one-cycle pulse while the raster is at (0,0)
- locked  out  1  alignment status; see Optional Feature

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (864); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (625).
- One clock; reset is asynchronous and active-high. All outputs are registered.
- x advances by 1 each clk. At H_TOTAL-1, x wraps to 0 and y advances. y wraps to 0 at V_TOTAL-1 when x wraps.
- Output decode:
  - de = (x < H_ACTIVE) && (y < V_ACTIVE).
  - hs is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (732..795).
  - vs is active for whole lines y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (581..585), aligned to line start x=0.
  - frame = (x==0 && y==0).
- hs, vs, de and frame are decoded from the next-state counters. They change on the same edge as x/y, so all outputs describe the same pixel (zero skew).
- Reset values (asserted immediately and held while reset is high):
  - x = H_TOTAL-1 (863), y = V_TOTAL-1 (624).
  - de = 0, frame = 0, locked = 0.
  - hs = ~HS_POL, vs = ~VS_POL (inactive).
  - The first rising edge after release yields x=0, y=0, de=1, frame=1.
- vreset sampled high at an edge: that same edge loads x=0, y=0 and decodes outputs for (0,0), so de=1 and frame=1 in the following cycle.
  - Any partial line or frame is truncated.
  - hs/vs drop inactive immediately if they were active.
- vreset at (H_TOTAL-1, V_TOTAL-1): result equals the natural wrap, so there is no visible disturbance.
- Back-to-back vreset cycles: each one reloads (0,0), so the raster holds at (0,0) until vreset deasserts.
- vreset while reset is high is ignored.
- Widths: x 12 bits and y 11 bits, unsigned. Comparisons are unsigned. Parameter sums must fit; H_TOTAL ≤ 4096 and V_TOTAL ≤ 2048 are required.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_LOCK_DET_EN.
- Defined:
  - An aligned vreset arrives when x==H_TOTAL-1 && y==V_TOTAL-1; any other vreset is misaligned.
  - A 2-bit saturating counter increments on each aligned vreset and clears on any misaligned vreset.
  - locked rises on the edge where the counter reaches 2.
  - locked falls on the edge of any misaligned vreset.
  - A missing vreset does not affect locked.
- Undefined: no detector logic is built; locked is tied to 0.

Test Plan:
- Release reset, free-run one line → de=1 for cycles 1..720; hs low for exactly 64 cycles starting at x=732; x wraps 863→0 with y 0→1.
- Free-run two frames → vs low for lines 581..585 (5×864 cycles); frame pulses exactly 540000 cycles apart; de never high for y≥576.
- Pulse vreset at x=100, y=200 → next cycle x=0, y=0, de=1, frame=1; following line length is 864.
- Pulse vreset while x=750 (hs active) → hs returns to 1 on the same edge that loads (0,0); no glitch cycle.
- With LOCK_DET_EN: vreset at (863,624) in two consecutive frames → locked=1 after the second; a later vreset at (10,10) → locked=0 on that edge. Without the macro, locked stays 0 throughout.
- Assert reset asynchronously mid-line at x=300, y=300 → outputs take reset values before the next clk edge; vreset during reset has no effect; normal restart at (0,0) after release.
